// File: rtl/adder_cpu_controller.sv
// Multi-cycle fetch/decode/execute controller for the adding-machine CPU, with halt, memory-timeout trap and retire counter.
// Latency: 3 cycles per instruction with mem_ready high; memory states stall on mem_ready=0 up to TIMEOUT cycles, then trap to ERR.
// Backpressure: mem_ready is the only handshake; control outputs hold steady while an access waits.
module adder_cpu_controller #(
    parameter int TIMEOUT = 15,
    parameter int ICNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        op_code,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic              ir_on_adr,
    output logic              pc_on_adr,
    output logic              ld_ir,
    output logic              ld_ac,
    output logic              ld_pc,
    output logic              inc_pc,
    output logic              clr_pc,
    output logic              pass_add,
    output logic              select,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic              halted,
    output logic              err,
    output logic [ICNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, EX_LDA, EX_STA, EX_JMP, EX_ADD, HALT, ERR
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ICNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic                mem_stall;
    logic                in_exec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST;
            wait_cnt_q  <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        instr_cnt_d = instr_cnt_q;
        mem_stall   = 1'b0;
        ir_on_adr   = 1'b0;
        pc_on_adr   = 1'b0;
        ld_ir       = 1'b0;
        ld_ac       = 1'b0;
        ld_pc       = 1'b0;
        inc_pc      = 1'b0;
        clr_pc      = 1'b0;
        pass_add    = 1'b0;
        select      = 1'b0;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;

        case (state_q)
            RST: begin
                clr_pc  = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                pc_on_adr = 1'b1;
                rd_mem    = 1'b1;
                if (mem_ready) begin
                    ld_ir   = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = DECODE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            DECODE: begin
                if (halt_req) begin
                    state_d = HALT;
                end else begin
                    case (op_code)
                        2'b00:   state_d = EX_LDA;
                        2'b01:   state_d = EX_STA;
                        2'b10:   state_d = EX_JMP;
                        default: state_d = EX_ADD;
                    endcase
                end
            end
            EX_LDA: begin
                ir_on_adr = 1'b1;
                rd_mem    = 1'b1;
                if (mem_ready) begin
                    ld_ac   = 1'b1;
                    state_d = FETCH;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            EX_STA: begin
                ir_on_adr = 1'b1;
                wr_mem    = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            EX_JMP: begin
                ld_pc   = 1'b1;
                state_d = FETCH;
            end
            EX_ADD: begin
                pass_add = 1'b1;
                select   = 1'b1;
                ld_ac    = 1'b1;
                state_d  = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    state_d = FETCH;
                end
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                state_d = RST;
            end
        endcase

        // A late mem_ready on the last allowed cycle still advances normally.
        if (mem_stall) begin
            if (wait_cnt_q == WAIT_LAST) begin
                state_d = ERR;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end

        if (in_exec && (state_d == FETCH)) begin
            instr_cnt_d = instr_cnt_q + ICNT_W'(1);
        end
    end

    assign in_exec   = (state_q == EX_LDA) || (state_q == EX_STA) ||
                       (state_q == EX_JMP) || (state_q == EX_ADD);
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_adder_cpu_controller.sv
// Bench for adder_cpu_controller: directed table, hand-written corner sequences and randomized run against a reference model.
module tb_adder_cpu_controller;

    localparam int TIMEOUT = 15;
    localparam int ICNT_W  = 8;

    localparam logic [12:0] O_IRA  = 13'h1000;
    localparam logic [12:0] O_PCA  = 13'h0800;
    localparam logic [12:0] O_LDIR = 13'h0400;
    localparam logic [12:0] O_LDAC = 13'h0200;
    localparam logic [12:0] O_LDPC = 13'h0100;
    localparam logic [12:0] O_INC  = 13'h0080;
    localparam logic [12:0] O_CLR  = 13'h0040;
    localparam logic [12:0] O_PASS = 13'h0020;
    localparam logic [12:0] O_SEL  = 13'h0010;
    localparam logic [12:0] O_RD   = 13'h0008;
    localparam logic [12:0] O_WR   = 13'h0004;
    localparam logic [12:0] O_HLT  = 13'h0002;
    localparam logic [12:0] O_ERR  = 13'h0001;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] op_code;
    logic mem_ready;
    logic halt_req;
    logic ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc;
    logic pass_add, select, rd_mem, wr_mem, halted, err;
    logic [ICNT_W-1:0] instr_cnt;
    logic [12:0] outs;

    always #5 clk = ~clk;

    adder_cpu_controller #(.TIMEOUT(TIMEOUT), .ICNT_W(ICNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_code   (op_code),
        .mem_ready (mem_ready),
        .halt_req  (halt_req),
        .ir_on_adr (ir_on_adr),
        .pc_on_adr (pc_on_adr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .clr_pc    (clr_pc),
        .pass_add  (pass_add),
        .select    (select),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .halted    (halted),
        .err       (err),
        .instr_cnt (instr_cnt)
    );

    assign outs = {ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc,
                   pass_add, select, rd_mem, wr_mem, halted, err};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the named step of the instruction cycle, cycles spent waiting, retired count.
    string      m_st   = "RST";
    int         m_wait = 0;
    logic [7:0] m_cnt  = 8'd0;

    typedef struct {
        logic       rdy;
        logic [1:0] op;
        logic       hr;
        logic [12:0] exp;
        logic [7:0]  cnt;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model step %s) at %0t", name, act, exp, m_st, $time);
        end
    endtask

    function automatic logic [12:0] model_outs(input logic rdy);
        if (m_st == "RST")    return O_CLR;
        if (m_st == "FETCH")  return O_PCA | O_RD | (rdy ? (O_LDIR | O_INC) : 13'h0);
        if (m_st == "DECODE") return 13'h0;
        if (m_st == "LDA")    return O_IRA | O_RD | (rdy ? O_LDAC : 13'h0);
        if (m_st == "STA")    return O_IRA | O_WR;
        if (m_st == "JMP")    return O_LDPC;
        if (m_st == "ADD")    return O_PASS | O_SEL | O_LDAC;
        if (m_st == "HALT")   return O_HLT;
        return O_ERR;
    endfunction

    task automatic model_advance(input logic rdy, input logic [1:0] op, input logic hr);
        string nxt;
        bit    is_ex;
        nxt   = m_st;
        is_ex = (m_st == "LDA") || (m_st == "STA") || (m_st == "JMP") || (m_st == "ADD");
        if (m_st == "RST") begin
            nxt = "FETCH";
        end else if (m_st == "FETCH" || m_st == "LDA" || m_st == "STA") begin
            if (rdy)                       nxt = (m_st == "FETCH") ? "DECODE" : "FETCH";
            else if (m_wait == TIMEOUT-1)  nxt = "ERR";
            else                           m_wait++;
        end else if (m_st == "DECODE") begin
            if (hr)             nxt = "HALT";
            else if (op == 0)   nxt = "LDA";
            else if (op == 1)   nxt = "STA";
            else if (op == 2)   nxt = "JMP";
            else                nxt = "ADD";
        end else if (m_st == "JMP" || m_st == "ADD") begin
            nxt = "FETCH";
        end else if (m_st == "HALT") begin
            if (!hr) nxt = "FETCH";
        end
        if (is_ex && nxt == "FETCH") m_cnt = m_cnt + 8'd1;
        if (nxt != m_st) m_wait = 0;
        m_st = nxt;
    endtask

    // Called just after a rising edge: drive inputs, check at the falling edge.
    task automatic apply(input logic rdy, input logic [1:0] op, input logic hr);
        mem_ready = rdy;
        op_code   = op;
        halt_req  = hr;
        @(negedge clk);
        check("outs_vs_model", outs, model_outs(rdy));
        check("cnt_vs_model", instr_cnt, m_cnt);
    endtask

    task automatic finish_cycle();
        model_advance(mem_ready, op_code, halt_req);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rdy, input logic [1:0] op, input logic hr);
        apply(rdy, op, hr);
        finish_cycle();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m_st   = "RST";
        m_wait = 0;
        m_cnt  = 8'd0;
        #1;
        check("reset_outs", outs, O_CLR);
        check("reset_cnt", instr_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 1'b0, O_CLR, 8'd0};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, O_PCA | O_RD | O_LDIR | O_INC, 8'd0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 13'h0, 8'd0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, O_IRA | O_RD | O_LDAC, 8'd0};
        tbl[4]  = '{1'b1, 2'd3, 1'b0, O_PCA | O_RD | O_LDIR | O_INC, 8'd1};
        tbl[5]  = '{1'b1, 2'd3, 1'b0, 13'h0, 8'd1};
        tbl[6]  = '{1'b1, 2'd3, 1'b0, O_PASS | O_SEL | O_LDAC, 8'd1};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, O_PCA | O_RD | O_LDIR | O_INC, 8'd2};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 13'h0, 8'd2};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, O_IRA | O_WR, 8'd2};
        tbl[10] = '{1'b1, 2'd2, 1'b0, O_PCA | O_RD | O_LDIR | O_INC, 8'd3};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 13'h0, 8'd3};
        tbl[12] = '{1'b1, 2'd2, 1'b0, O_LDPC, 8'd3};

        rst_n     = 1'b1;
        mem_ready = 1'b1;
        op_code   = 2'd0;
        halt_req  = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then LDA/ADD/STA/JMP at full speed.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].rdy, tbl[i].op, tbl[i].hr);
            check($sformatf("table_outs[%0d]", i), outs, tbl[i].exp);
            check($sformatf("table_cnt[%0d]", i), instr_cnt, tbl[i].cnt);
            finish_cycle();
        end

        // Fetch stalled for three cycles.
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'd0, 1'b0);
            check("stall_cnt4", instr_cnt, 4);
            check("stall_rd", rd_mem, 1);
            check("stall_ldir", {ld_ir, inc_pc}, 2'b00);
            finish_cycle();
        end
        apply(1'b1, 2'd0, 1'b0);
        check("stall_release", {rd_mem, ld_ir, inc_pc}, 3'b111);
        finish_cycle();
        step(1'b1, 2'd0, 1'b0);

        // LDA whose memory never answers.
        for (int i = 0; i < TIMEOUT; i++) begin
            apply(1'b0, 2'd0, 1'b0);
            check("lda_wait_rd", {ir_on_adr, rd_mem, err}, 3'b110);
            finish_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 2'd3, 1'b1);
            check("err_outs", outs, O_ERR);
            finish_cycle();
        end

        // Halt requested during fetch.
        do_reset();
        step(1'b1, 2'd3, 1'b0);
        apply(1'b1, 2'd3, 1'b1);
        check("halt_fetch_ldir", ld_ir, 1);
        finish_cycle();
        step(1'b1, 2'd3, 1'b1);
        apply(1'b1, 2'd3, 1'b1);
        check("halted", outs, O_HLT);
        finish_cycle();
        apply(1'b1, 2'd3, 1'b0);
        check("halted_drop", halted, 1);
        finish_cycle();
        apply(1'b1, 2'd3, 1'b0);
        check("resume_fetch", {pc_on_adr, halted}, 2'b10);
        finish_cycle();

        // 256 ADDs wrap the counter, then a reset lands mid-STA.
        do_reset();
        step(1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                apply(1'b1, 2'd3, 1'b0);
                check("cnt_255", instr_cnt, 255);
                finish_cycle();
            end else begin
                step(1'b1, 2'd3, 1'b0);
            end
            step(1'b1, 2'd3, 1'b0);
            step(1'b1, 2'd3, 1'b0);
        end
        apply(1'b1, 2'd1, 1'b0);
        check("cnt_wrap", instr_cnt, 0);
        finish_cycle();
        step(1'b1, 2'd1, 1'b0);
        apply(1'b0, 2'd1, 1'b0);
        check("sta_wr", wr_mem, 1);
        rst_n  = 1'b0;
        m_st   = "RST";
        m_wait = 0;
        m_cnt  = 8'd0;
        #1;
        check("sta_reset_wr", {wr_mem, clr_pc}, 2'b01);
        check("sta_reset_cnt", instr_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic with periodic stall-heavy phases.
        for (int n = 0; n < 3000; n++) begin
            logic r;
            if ((n % 300) < 60) r = ($urandom_range(7) == 0);
            else                r = ($urandom_range(3) != 0);
            if ((m_st == "ERR" && $urandom_range(3) == 0) || $urandom_range(199) == 0) begin
                do_reset();
            end else begin
                step(r, 2'($urandom_range(3)), ($urandom_range(15) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
